edge_detector_bank: RTL and testbench

//  Multi-channel, parametrised edge detector for asynchronous/noisy control inputs.
//  Per channel: synchroniser, glitch filter and per-channel edge mode selection
//  (rise/fall/both/off), producing a one-cycle edge pulse.

---
 rtl/edge_detector_bank.sv | 103 ++++++++++
 tb/tb_edge_detector_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, mode-gated
// one-cycle edge pulse, sticky flag and saturating edge counter.

module edge_det_lane #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int CNT_W       = 8
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic             i_signal,
   input  logic [1:0]       i_mode,
   input  logic             i_clr,
   output logic             o_pulse_nxt,
   output logic             o_pulse,
   output logic             o_rising,
   output logic             o_level,
   output logic             o_flag,
   output logic [CNT_W-1:0] o_count
);
   localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FW-1:0] LAST = FW'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FW-1:0]          fcnt;
   logic                   sync, mismatch, accept;

   assign sync     = sync_q[SYNC_STAGES-1];
   assign mismatch = (sync != o_level);
   // With FILT_LEN = 1, LAST is 0 and fcnt never leaves 0, so any mismatch is accepted.
   assign accept   = mismatch && (fcnt == LAST);
   // bit 0 enables rising edges, bit 1 enables falling edges
   assign o_pulse_nxt = accept && (sync ? i_mode[0] : i_mode[1]);

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         sync_q   <= '0;
         fcnt     <= '0;
         o_level  <= 1'b0;
         o_pulse  <= 1'b0;
         o_rising <= 1'b0;
         o_flag   <= 1'b0;
         o_count  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], i_signal};
         fcnt    <= (!mismatch || accept) ? '0 : fcnt + 1'b1;
         o_pulse <= o_pulse_nxt;
         if (accept)      o_level  <= sync;
         if (o_pulse_nxt) o_rising <= sync;
         if (o_pulse_nxt)  o_flag <= 1'b1;
         else if (i_clr)   o_flag <= 1'b0;
         // clear with a coincident edge counts that edge
         if (i_clr)                            o_count <= CNT_W'(o_pulse_nxt);
         else if (o_pulse_nxt && o_count != '1) o_count <= o_count + 1'b1;
      end
   end
endmodule

module edge_detector_bank #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int CNT_W       = 8
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic [N_CH-1:0]       i_signal,
   input  logic [2*N_CH-1:0]     i_mode,
   input  logic [N_CH-1:0]       i_clr,
   output logic [N_CH-1:0]       o_pulse,
   output logic [N_CH-1:0]       o_rising,
   output logic [N_CH-1:0]       o_level,
   output logic [N_CH-1:0]       o_flag,
   output logic                  o_any,
   output logic [N_CH*CNT_W-1:0] o_count
);
   logic [N_CH-1:0] pulse_nxt;

   for (genvar c = 0; c < N_CH; c++) begin : g_lane
      edge_det_lane #(
         .SYNC_STAGES(SYNC_STAGES),
         .FILT_LEN   (FILT_LEN),
         .CNT_W      (CNT_W)
      ) u_lane (
         .i_clk      (i_clk),
         .i_arst     (i_arst),
         .i_signal   (i_signal[c]),
         .i_mode     (i_mode[2*c +: 2]),
         .i_clr      (i_clr[c]),
         .o_pulse_nxt(pulse_nxt[c]),
         .o_pulse    (o_pulse[c]),
         .o_rising   (o_rising[c]),
         .o_level    (o_level[c]),
         .o_flag     (o_flag[c]),
         .o_count    (o_count[c*CNT_W +: CNT_W])
      );
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) o_any <= 1'b0;
      else        o_any <= |pulse_nxt;
   end
endmodule

// File: tb/tb_edge_detector_bank.sv
// Bench for edge_detector_bank: directed scenarios plus a cycle-level reference
// model whose per-edge predictions are queued and compared on the falling edge.

module tb_edge_detector_bank;
   localparam int N = 4, S = 2, F = 3, CW = 8, CWS = 2;

   logic           i_clk = 1'b0;
   logic           i_arst;
   logic [N-1:0]   sig, clr;
   logic [2*N-1:0] mode;
   logic [N-1:0]   o_pulse, o_rising, o_level, o_flag;
   logic [N-1:0]   s_pulse, s_rising, s_level, s_flag;
   logic           o_any, s_any;
   logic [N*CW-1:0]  o_count;
   logic [N*CWS-1:0] s_count;

   int total = 0, bad = 0;
   int pcnt [N];
   int prise[N];

   always #5 i_clk = ~i_clk;

   edge_detector_bank #(.N_CH(N), .SYNC_STAGES(S), .FILT_LEN(F), .CNT_W(CW)) dut (
      .i_clk(i_clk), .i_arst(i_arst), .i_signal(sig), .i_mode(mode), .i_clr(clr),
      .o_pulse(o_pulse), .o_rising(o_rising), .o_level(o_level), .o_flag(o_flag),
      .o_any(o_any), .o_count(o_count));

   edge_detector_bank #(.N_CH(N), .SYNC_STAGES(S), .FILT_LEN(F), .CNT_W(CWS)) dut_s (
      .i_clk(i_clk), .i_arst(i_arst), .i_signal(sig), .i_mode(mode), .i_clr(clr),
      .o_pulse(s_pulse), .o_rising(s_rising), .o_level(s_level), .o_flag(s_flag),
      .o_any(s_any), .o_count(s_count));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model
   typedef struct packed {
      logic [N-1:0]     pulse, rising, level, flag;
      logic             any;
      logic [N*CW-1:0]  cnt;
      logic [N*CWS-1:0] cnts;
   } exp_t;
   exp_t sb[$];

   logic m_sh  [N][S];
   logic m_lvl [N];
   int   m_run [N];
   int   m_cnt [N];
   int   m_cnts[N];
   logic [N-1:0] m_pulse, m_rise, m_flag;

   always @(posedge i_clk or posedge i_arst) begin : mdl
      exp_t e;
      logic s, acc, p;
      if (i_arst) begin
         for (int c = 0; c < N; c++) begin
            for (int k = 0; k < S; k++) m_sh[c][k] = 1'b0;
            m_lvl[c] = 1'b0; m_run[c] = 0; m_cnt[c] = 0; m_cnts[c] = 0;
         end
         m_pulse = '0; m_rise = '0; m_flag = '0;
         sb.delete();
      end else begin
         e = '0;
         for (int c = 0; c < N; c++) begin
            s   = m_sh[c][S-1];
            acc = 1'b0;
            if (s != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == F) begin
                  acc = 1'b1; m_run[c] = 0; m_lvl[c] = s;
               end
            end else m_run[c] = 0;
            p = acc && (s ? mode[2*c] : mode[2*c+1]);
            m_pulse[c] = p;
            if (p) m_rise[c] = s;
            if (p) m_flag[c] = 1'b1;
            else if (clr[c]) m_flag[c] = 1'b0;
            if (clr[c]) begin
               m_cnt[c] = int'(p); m_cnts[c] = int'(p);
            end else if (p) begin
               if (m_cnt[c]  < (1 << CW)  - 1) m_cnt[c]++;
               if (m_cnts[c] < (1 << CWS) - 1) m_cnts[c]++;
            end
            for (int k = S - 1; k > 0; k--) m_sh[c][k] = m_sh[c][k-1];
            m_sh[c][0] = sig[c];
            e.level[c]           = m_lvl[c];
            e.cnt[c*CW +: CW]    = CW'(m_cnt[c]);
            e.cnts[c*CWS +: CWS] = CWS'(m_cnts[c]);
         end
         e.pulse = m_pulse; e.rising = m_rise; e.flag = m_flag; e.any = |m_pulse;
         sb.push_back(e);
      end
   end

   always @(negedge i_clk) begin : mon
      exp_t e;
      if (!i_arst) begin
         for (int c = 0; c < N; c++) if (o_pulse[c]) begin
            pcnt[c]++;
            if (o_rising[c]) prise[c]++;
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pulse",  o_pulse,  e.pulse);
            chk("sb_rising", o_rising, e.rising);
            chk("sb_level",  o_level,  e.level);
            chk("sb_flag",   o_flag,   e.flag);
            chk("sb_any",    o_any,    e.any);
            chk("sb_count",  o_count,  e.cnt);
            chk("sb_count_s", s_count, e.cnts);
            chk("sb_flag_s",  s_flag,  e.flag);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge i_clk);
      #1;
   endtask

   task automatic clr_stats();
      for (int c = 0; c < N; c++) begin pcnt[c] = 0; prise[c] = 0; end
   endtask

   // posedges until the selected condition appears, 0 if the bound expires
   task automatic wait_pulse(input int ch, output int lat);
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge i_clk); #1;
         if ((ch < 0) ? o_any : o_pulse[ch]) begin lat = k; break; end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pulse"}, o_pulse, '0);
      chk({tag, "_level"}, o_level, '0);
      chk({tag, "_flag"},  o_flag,  '0);
      chk({tag, "_any"},   o_any,   1'b0);
      chk({tag, "_rise"},  o_rising, '0);
      chk({tag, "_count"}, o_count, '0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      clr_stats();
      sig = '0; mode = '0; clr = '0; i_arst = 1'b1;
      #2;
      chk_zero("reset");
      cyc(2);
      i_arst = 1'b0;

      // single rising edge, latency and width
      mode = 8'b0000_0001;
      cyc(1);
      sig[0] = 1'b1;
      wait_pulse(0, lat);
      chk("t1_lat", lat, 5);
      chk("t1_rise", o_rising[0], 1'b1);
      chk("t1_level", o_level[0], 1'b1);
      chk("t1_count", o_count[CW-1:0], 1);
      @(posedge i_clk); #1;
      chk("t1_width", o_pulse[0], 1'b0);

      // glitch rejection then acceptance
      mode = 8'b0000_1101;
      cyc(1);
      clr_stats();
      sig[1] = 1'b1; cyc(2); sig[1] = 1'b0; cyc(8);
      chk("t2_glitch_lvl", o_level[1], 1'b0);
      chk("t2_glitch_cnt", o_count[CW +: CW], 0);
      chk("t2_glitch_np", pcnt[1], 0);
      sig[1] = 1'b1; cyc(3); sig[1] = 1'b0; cyc(12);
      chk("t2_pulses", pcnt[1], 2);
      chk("t2_rises", prise[1], 1);

      // modes off/rise/fall/both
      mode = '0; sig = '0; cyc(10);
      mode = 8'b1110_0100;
      clr_stats();
      sig = 4'hF; cyc(10); sig = 4'h0; cyc(12);
      chk("t3_n_off",  pcnt[0], 0);
      chk("t3_n_rise", pcnt[1], 1);
      chk("t3_n_fall", pcnt[2], 1);
      chk("t3_n_both", pcnt[3], 2);
      chk("t3_r_rise", prise[1], 1);
      chk("t3_r_fall", prise[2], 0);
      chk("t3_r_both", prise[3], 1);

      // saturation and clear
      mode = 8'b1111_1111;
      clr = 4'hF; cyc(1); clr = '0;
      for (int i = 0; i < 5; i++) begin sig[0] = ~sig[0]; cyc(8); end
      chk("t4_sat", s_count[CWS-1:0], 3);
      chk("t4_cnt5", o_count[CW-1:0], 5);
      sig[0] = ~sig[0];
      cyc(4);
      clr[0] = 1'b1;
      @(posedge i_clk); #1;
      chk("t4_co_pulse", o_pulse[0], 1'b1);
      chk("t4_co_cnt_s", s_count[CWS-1:0], 1);
      chk("t4_co_cnt", o_count[CW-1:0], 1);
      chk("t4_co_flag", o_flag[0], 1'b1);
      cyc(1); clr[0] = 1'b0;
      cyc(3); clr[0] = 1'b1; cyc(1); clr[0] = 1'b0;
      chk("t4_lone_cnt", s_count[CWS-1:0], 0);
      chk("t4_lone_flag", o_flag[0], 1'b0);

      // reset mid-filter, then mid-pulse
      sig[2] = 1'b1;
      repeat (3) @(posedge i_clk);
      #2 i_arst = 1'b1;
      #1 chk_zero("t5_mf");
      cyc(1); i_arst = 1'b0;
      wait_pulse(2, lat);
      chk("t5_lat1", lat, 5);
      i_arst = 1'b1;
      #1 chk_zero("t5_mp");
      cyc(1); i_arst = 1'b0;
      wait_pulse(2, lat);
      chk("t5_lat2", lat, 5);
      chk("t5_rise", o_rising[2], 1'b1);

      // all channels at once
      sig = '0; cyc(10);
      sig = 4'hF;
      wait_pulse(-1, lat);
      chk("t6_lat", lat, 5);
      chk("t6_all", o_pulse, 4'hF);
      @(posedge i_clk); #1;
      chk("t6_any_w", o_any, 1'b0);

      // random asynchronous stimulus against the model
      for (int i = 0; i < 500; i++) begin
         @(negedge i_clk);
         #($urandom_range(1, 4));
         if ($urandom_range(0, 5) == 0) sig[$urandom_range(0, N-1)] ^= 1'b1;
         if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
         clr = ($urandom_range(0, 24) == 0) ? 4'($urandom) : '0;
         if ($urandom_range(0, 9) == 0) begin
            sig[1] ^= 1'b1; #1; sig[1] ^= 1'b1;
         end
      end
      clr = '0;
      cyc(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
